// File: rtl/uartrx_maxis_pkg.sv
// rtl/uartrx_maxis_pkg.sv - shared types, character constants and helpers for the hex UART receiver
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;

  // Returns {is_hex, nibble}; nibble is 0 when is_hex is 0.
  function automatic logic [4:0] ascii2hex(input logic [7:0] ch);
    logic [4:0] r;
    r = '0;
    if (ch >= 8'h30 && ch <= 8'h39)      r = {1'b1, 4'(ch - 8'h30)};
    else if (ch >= 8'h41 && ch <= 8'h46) r = {1'b1, 4'(ch - 8'h37)};
    else if (ch >= 8'h61 && ch <= 8'h66) r = {1'b1, 4'(ch - 8'h57)};
    return r;
  endfunction

  function automatic int hex_digits(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/uartrx_maxis_if.sv
// rtl/uartrx_maxis_if.sv - AXI-stream word channel carrying parsed hex words
interface uartrx_maxis_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/uartrx_maxis_word_fifo.sv
// rtl/uartrx_maxis_word_fifo.sv - show-ahead word FIFO with a registered AXI-stream output stage
module uartrx_word_fifo
  import uart_pkg::*;
#(
  parameter int DW    = 64,
  parameter int ASIZE = 8
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          i_push,
  input  logic [DW:0]   i_push_data,
  output logic          o_full,
  uartrx_maxis_if.master m_axis
);

  localparam int DEPTH = 2 ** ASIZE;

  logic [DW:0]    r_mem [DEPTH];
  logic [ASIZE:0] r_wr_ptr;
  logic [ASIZE:0] r_rd_ptr;
  logic           r_tvalid;
  logic [DW-1:0]  r_tdata;
  logic           r_tlast;

  logic w_empty;
  logic w_full_raw;
  logic w_load;
  logic w_wr;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full_raw = (r_wr_ptr[ASIZE] != r_rd_ptr[ASIZE]) &&
                      (r_wr_ptr[ASIZE-1:0] == r_rd_ptr[ASIZE-1:0]);
  assign w_load     = !w_empty && (!r_tvalid || m_axis.tready);
  // A slot freed by this cycle's move into the output register can take this cycle's push.
  assign o_full     = w_full_raw && !w_load;
  assign w_wr       = i_push && !o_full;

  always_ff @(posedge aclk) begin
    if (w_wr) r_mem[r_wr_ptr[ASIZE-1:0]] <= i_push_data;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_tvalid <= 1'b1;
        {r_tlast, r_tdata} <= r_mem[r_rd_ptr[ASIZE-1:0]];
      end else if (m_axis.tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tlast  = r_tlast;

endmodule

// File: rtl/uartrx_maxis.sv
// rtl/uartrx_maxis.sv - UART 8N1 receiver parsing whitespace-delimited hex text into AXI-stream words
module uartrx_maxis
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_ASIZE = 8
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic           uart_rx,
  uartrx_maxis_if.master m_axis,
  output logic           overflow,
  output logic           frame_err,
  output logic           char_err
);

  localparam int CW = $clog2(CLK_DIV);

  logic r_rx_meta;
  logic r_rxs;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rxs     <= r_rx_meta;
    end
  end

  rx_state_t r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    r_idx, w_idx_next;
  logic [7:0]    r_shreg, w_shreg_next;
  logic          r_byte_vld, w_byte_vld_next;
  logic          r_frame_err, w_frame_err_next;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shreg     <= '0;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_idx       <= w_idx_next;
      r_shreg     <= w_shreg_next;
      r_byte_vld  <= w_byte_vld_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
    w_idx_next       = r_idx;
    w_shreg_next     = r_shreg;
    w_byte_vld_next  = 1'b0;
    w_frame_err_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rxs) begin
          w_cnt_next   = CW'(CLK_DIV / 2 - 1);
          w_state_next = START;
        end
      end
      START: begin
        if (r_cnt == '0) begin
          if (r_rxs) begin
            w_state_next = IDLE;
          end else begin
            w_cnt_next   = CW'(CLK_DIV - 1);
            w_idx_next   = 3'd0;
            w_state_next = DATA;
          end
        end
      end
      DATA: begin
        if (r_cnt == '0) begin
          w_shreg_next[r_idx] = r_rxs;
          w_cnt_next          = CW'(CLK_DIV - 1);
          w_idx_next          = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_next = STOP;
        end
      end
      STOP: begin
        if (r_cnt == '0) begin
          w_byte_vld_next  = r_rxs;
          w_frame_err_next = !r_rxs;
          w_state_next     = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  logic [4:0]            w_hex;
  logic                  w_delim;
  logic [DATA_WIDTH+3:0] w_shift;
  logic                  w_full;

  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_have_digit;
  logic                  r_bad;
  logic                  r_push;
  logic [DATA_WIDTH:0]   r_push_data;
  logic                  r_char_err;
  logic                  r_overflow;

  assign w_hex   = ascii2hex(r_shreg);
  assign w_delim = (r_shreg == CH_SP) || (r_shreg == CH_TAB) || (r_shreg == CH_LF);
  assign w_shift = {r_acc, w_hex[3:0]};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_acc        <= '0;
      r_have_digit <= 1'b0;
      r_bad        <= 1'b0;
      r_push       <= 1'b0;
      r_push_data  <= '0;
      r_char_err   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_push     <= 1'b0;
      r_char_err <= 1'b0;
      if (r_push && w_full) r_overflow <= 1'b1;
      if (r_byte_vld) begin
        if (w_hex[4]) begin
          r_acc        <= w_shift[DATA_WIDTH-1:0];
          r_have_digit <= 1'b1;
        end else if (w_delim) begin
          r_push       <= r_have_digit && !r_bad;
          r_push_data  <= {(r_shreg == CH_LF), r_acc};
          r_acc        <= '0;
          r_have_digit <= 1'b0;
          r_bad        <= 1'b0;
        end else if (r_shreg != CH_CR) begin
          r_char_err <= 1'b1;
          r_bad      <= 1'b1;
        end
      end
    end
  end

  uartrx_word_fifo #(
    .DW    (DATA_WIDTH),
    .ASIZE (FIFO_ASIZE)
  ) u_fifo (
    .aclk        (aclk),
    .areset      (areset),
    .i_push      (r_push),
    .i_push_data (r_push_data),
    .o_full      (w_full),
    .m_axis      (m_axis)
  );

  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;
  assign char_err  = r_char_err;

endmodule

// File: tb/tb_uartrx_maxis.sv
// tb/tb_uartrx_maxis.sv - self-checking bench for the hex UART receiver
module tb_uartrx_maxis;

  localparam int CLK_DIV = 8;
  localparam int DW      = 32;
  localparam int ASIZE   = 2;

  logic aclk;
  logic areset;
  logic uart_rx;
  logic overflow;
  logic frame_err;
  logic char_err;

  uartrx_maxis_if #(.DATA_WIDTH(DW)) axis ();

  uartrx_maxis #(
    .CLK_DIV    (CLK_DIV),
    .DATA_WIDTH (DW),
    .FIFO_ASIZE (ASIZE)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .uart_rx   (uart_rx),
    .m_axis    (axis),
    .overflow  (overflow),
    .frame_err (frame_err),
    .char_err  (char_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [127:0] text;
    logic [7:0]   len;
    logic [7:0]   n_beats;
    logic [32:0]  b0;
    logic [32:0]  b1;
    logic [7:0]   n_cerr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt = 0;
  int cerr_cnt = 0;
  logic [32:0] beats [$];

  always @(negedge aclk) begin
    if (!areset) begin
      if (axis.tvalid && axis.tready) beats.push_back({axis.tlast, axis.tdata});
      if (frame_err) ferr_cnt++;
      if (char_err) cerr_cnt++;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CLK_DIV) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLK_DIV) tick();
    end
    uart_rx = stop;
    repeat (CLK_DIV) tick();
    uart_rx = 1'b1;
    if (!stop) repeat (CLK_DIV) tick();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  function automatic vec_t mk(input string s, input int nb, input logic [32:0] b0,
                              input logic [32:0] b1, input int ce);
    vec_t v;
    v = '0;
    for (int i = 0; i < s.len() && i < 16; i++) v.text[8*i +: 8] = s[i];
    v.len     = 8'(s.len());
    v.n_beats = 8'(nb);
    v.b0      = b0;
    v.b1      = b1;
    v.n_cerr  = 8'(ce);
    return v;
  endfunction

  function automatic logic [63:0] beat_at(input int idx);
    if (idx < beats.size()) return {31'd0, beats[idx]};
    return 64'hDEAD_BEEF_0000_0000;
  endfunction

  vec_t vecs [6];

  initial begin
    int base;
    int fbase;
    int cbase;

    vecs[0] = mk("1a2B3c4D\n", 1, {1'b1, 32'h1A2B3C4D}, 33'd0, 0);
    vecs[1] = mk("12 ff\n", 2, {1'b0, 32'h12}, {1'b1, 32'hFF}, 0);
    vecs[2] = mk("  \r\n", 0, 33'd0, 33'd0, 0);
    vecs[3] = mk("123456789\n", 1, {1'b1, 32'h23456789}, 33'd0, 0);
    vecs[4] = mk("12G4 5\n", 1, {1'b1, 32'h5}, 33'd0, 1);
    vecs[5] = mk("7\t\n", 1, {1'b0, 32'h7}, 33'd0, 0);

    areset      = 1'b1;
    uart_rx     = 1'b1;
    axis.tready = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", {63'd0, axis.tvalid}, 64'd0);
    check("rst_tdata", {32'd0, axis.tdata}, 64'd0);
    check("rst_tlast", {63'd0, axis.tlast}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_frame_err", {63'd0, frame_err}, 64'd0);
    check("rst_char_err", {63'd0, char_err}, 64'd0);
    areset = 1'b0;
    repeat (4) tick();

    for (int v = 0; v < 6; v++) begin
      base  = beats.size();
      cbase = cerr_cnt;
      fbase = ferr_cnt;
      for (int i = 0; i < int'(vecs[v].len); i++) send_byte(vecs[v].text[8*i +: 8], 1'b1);
      repeat (30) tick();
      check($sformatf("vec%0d_nbeats", v), 64'(beats.size() - base), 64'(vecs[v].n_beats));
      if (vecs[v].n_beats > 0) check($sformatf("vec%0d_beat0", v), beat_at(base), {31'd0, vecs[v].b0});
      if (vecs[v].n_beats > 1) check($sformatf("vec%0d_beat1", v), beat_at(base + 1), {31'd0, vecs[v].b1});
      check($sformatf("vec%0d_char_err", v), 64'(cerr_cnt - cbase), 64'(vecs[v].n_cerr));
      check($sformatf("vec%0d_frame_err", v), 64'(ferr_cnt - fbase), 64'd0);
    end

    // Bad stop bit: byte discarded, so the following LF has nothing to terminate.
    base  = beats.size();
    fbase = ferr_cnt;
    send_byte(8'h31, 1'b0);
    repeat (20) tick();
    check("ferr_pulse", 64'(ferr_cnt - fbase), 64'd1);
    send_str("\n");
    repeat (30) tick();
    check("ferr_no_beat", 64'(beats.size() - base), 64'd0);

    base  = beats.size();
    fbase = ferr_cnt;
    cbase = cerr_cnt;
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (100) tick();
    check("glitch_no_ferr", 64'(ferr_cnt - fbase), 64'd0);
    check("glitch_no_cerr", 64'(cerr_cnt - cbase), 64'd0);
    check("glitch_no_beat", 64'(beats.size() - base), 64'd0);
    send_str("9\n");
    repeat (30) tick();
    check("glitch_nbeats", 64'(beats.size() - base), 64'd1);
    check("glitch_beat", beat_at(base), {31'd0, 1'b1, 32'h9});

    // Stall the consumer: 4 FIFO slots plus the output register hold words 1..5.
    base = beats.size();
    axis.tready = 1'b0;
    send_str("1 2 3 4 5 6 7\n");
    repeat (30) tick();
    check("ovf_flag", {63'd0, overflow}, 64'd1);
    check("ovf_tvalid", {63'd0, axis.tvalid}, 64'd1);
    check("ovf_tdata", {32'd0, axis.tdata}, 64'h1);
    repeat (7) tick();
    check("ovf_tdata_stable", {32'd0, axis.tdata}, 64'h1);
    check("ovf_no_beat", 64'(beats.size() - base), 64'd0);
    axis.tready = 1'b1;
    repeat (20) tick();
    check("ovf_nbeats", 64'(beats.size() - base), 64'd5);
    for (int k = 0; k < 5; k++)
      check($sformatf("ovf_beat%0d", k), beat_at(base + k), 64'(k + 1));
    check("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Reset in the middle of the 'C' byte after "AB".
    send_str("AB");
    uart_rx = 1'b0;
    repeat (CLK_DIV) tick();
    uart_rx = 1'b1;
    repeat (CLK_DIV) tick();
    areset = 1'b1;
    tick();
    check("mid_rst_tvalid", {63'd0, axis.tvalid}, 64'd0);
    check("mid_rst_tdata", {32'd0, axis.tdata}, 64'd0);
    check("mid_rst_tlast", {63'd0, axis.tlast}, 64'd0);
    check("mid_rst_overflow", {63'd0, overflow}, 64'd0);
    repeat (2) tick();
    areset = 1'b0;
    repeat (20) tick();
    base = beats.size();
    send_str("C\n");
    repeat (30) tick();
    check("post_rst_nbeats", 64'(beats.size() - base), 64'd1);
    check("post_rst_beat", beat_at(base), {31'd0, 1'b1, 32'hC});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
